// File: rtl/tile_xy_mort_sink_if.sv
// Bundle of the upstream mortgage-FIFO pop side and the local cache write-beat side.
// The sink drives through the master modport; the surrounding logic uses slave.
interface tile_xy_mort_sink_if;
   logic         in_avail;
   logic         in_take;
   logic [527:0] in_data;
   logic [46:0]  in_addr;
   logic [11:0]  in_size;
   logic         in_expun;

   logic         wr_valid;
   logic         wr_ready;
   logic [131:0] wr_data;
   logic [46:0]  wr_addr;
   logic [11:0]  wr_size;
   logic [1:0]   wr_beat;
   logic         wr_first;
   logic         wr_last;
   logic         wr_expun;

   logic [4:0]   occ;
   logic [15:0]  line_cnt;

   modport master (
      input  in_avail, in_data, in_addr, in_size, in_expun, wr_ready,
      output in_take, wr_valid, wr_data, wr_addr, wr_size, wr_beat,
             wr_first, wr_last, wr_expun, occ, line_cnt
   );

   modport slave (
      output in_avail, in_data, in_addr, in_size, in_expun, wr_ready,
      input  in_take, wr_valid, wr_data, wr_addr, wr_size, wr_beat,
             wr_first, wr_last, wr_expun, occ, line_cnt
   );
endinterface

// File: rtl/tile_xy_mort_sink.sv
// Drains mortgage entries from an upstream tile FIFO into a local buffer
// and replays each 528-bit line as four 132-bit cache write beats.
module tile_xy_mort_sink #(
   parameter int DEPTH = 4,
   parameter int BEATS = 4
) (
   input  logic                clk,
   input  logic                rst,
   tile_xy_mort_sink_if.master bus
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int EW = 528 + 47 + 12 + 1;
   localparam logic [4:0] DEPTH5 = 5'(DEPTH);
   localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t        state, state_nx;
   logic [EW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_inc, head_sel;
   logic [4:0]    occ;
   logic [15:0]   line_cnt;
   logic [1:0]    beat, beat_nx;
   logic          push, pop, load_fifo, load_in, handshake, last_beat;

   logic [527:0]  cur_data;
   logic [46:0]   cur_addr;
   logic [11:0]   cur_size;
   logic          cur_expun;

   assign push       = bus.in_avail & (occ < DEPTH5) & ~rst;
   assign rd_ptr_inc = rd_ptr + 1'b1;
   assign handshake  = (state == SEND) & bus.wr_ready;
   assign last_beat  = cur_expun | (beat == LAST_BEAT);
   // The entry being sent stays at the FIFO head, so its successor sits one past rd_ptr.
   assign head_sel   = (state == SEND) ? rd_ptr_inc : rd_ptr;

   always_comb begin
      state_nx  = state;
      beat_nx   = beat;
      pop       = 1'b0;
      load_fifo = 1'b0;
      load_in   = 1'b0;
      case (state)
         IDLE: begin
            if (occ != 5'd0) begin
               load_fifo = 1'b1;
               state_nx  = SEND;
               beat_nx   = 2'd0;
            end else if (push) begin
               load_in  = 1'b1;
               state_nx = SEND;
               beat_nx  = 2'd0;
            end
         end
         SEND: begin
            if (handshake) begin
               if (!last_beat) begin
                  beat_nx = beat + 2'd1;
               end else begin
                  pop     = 1'b1;
                  beat_nx = 2'd0;
                  if (occ > 5'd1) begin
                     load_fifo = 1'b1;
                  end else if (push) begin
                     load_in = 1'b1;
                  end else begin
                     state_nx = IDLE;
                  end
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         beat     <= 2'd0;
         occ      <= 5'd0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         line_cnt <= 16'd0;
      end else begin
         state <= state_nx;
         beat  <= beat_nx;
         occ   <= occ + {4'd0, push} - {4'd0, pop};
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr_inc;
         if (pop && !cur_expun) line_cnt <= line_cnt + 16'd1;
      end
   end

   // Storage and the output line register carry no reset; validity comes from occ/state.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {bus.in_data, bus.in_addr, bus.in_size, bus.in_expun};
      if (load_fifo) begin
         {cur_data, cur_addr, cur_size, cur_expun} <= mem[head_sel];
      end else if (load_in) begin
         {cur_data, cur_addr, cur_size, cur_expun} <=
            {bus.in_data, bus.in_addr, bus.in_size, bus.in_expun};
      end
   end

   assign bus.in_take  = push;
   assign bus.wr_valid = (state == SEND);
   assign bus.wr_data  = cur_expun ? 132'd0 : cur_data[beat*132 +: 132];
   assign bus.wr_addr  = cur_addr;
   assign bus.wr_size  = cur_size;
   assign bus.wr_beat  = beat;
   assign bus.wr_first = (beat == 2'd0);
   assign bus.wr_last  = last_beat;
   assign bus.wr_expun = cur_expun;
   assign bus.occ      = occ;
   assign bus.line_cnt = line_cnt;

endmodule

// File: tb/tb_tile_xy_mort_sink.sv
// Randomised scoreboard bench for tile_xy_mort_sink: accepted entries expand
// into expected beats in a queue that a negedge monitor pops and compares.
module tb_tile_xy_mort_sink;

   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   tile_xy_mort_sink_if bus ();

   tile_xy_mort_sink #(.DEPTH(DEPTH), .BEATS(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   typedef struct {
      logic [131:0] data;
      logic [46:0]  addr;
      logic [11:0]  size;
      logic [1:0]   beat;
      logic         first;
      logic         last;
      logic         expun;
   } beat_t;

   beat_t       sq[$];
   int          tests = 0;
   int          fails = 0;
   int          m_occ = 0;
   logic [15:0] m_lines = 16'd0;

   task automatic checkOutput(input string name, input logic [131:0] act, input logic [131:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [527:0] randData();
      logic [543:0] t;
      for (int i = 0; i < 17; i++) t[i*32 +: 32] = $urandom;
      return t[527:0];
   endfunction

   // Drive one cycle of inputs just after a rising edge, then wait for the next.
   task automatic applyStimulus(input logic avail, input logic ready, input logic expun,
                                input logic [46:0] addr, input logic [527:0] data);
      bus.in_avail = avail;
      bus.wr_ready = ready;
      bus.in_expun = expun;
      bus.in_addr  = addr;
      bus.in_data  = data;
      bus.in_size  = 12'($urandom);
      @(posedge clk);
      #1;
   endtask

   // Monitor: reference model is a queue of expected beats plus occupancy/line counters.
   always @(negedge clk) begin
      beat_t b;
      if (rst) begin
         checkOutput("in_take_in_reset", bus.in_take, 1'b0);
         sq.delete();
         m_occ   = 0;
         m_lines = 16'd0;
      end else begin
         checkOutput("occ", bus.occ, m_occ);
         checkOutput("line_cnt", bus.line_cnt, m_lines);
         checkOutput("in_take", bus.in_take, bus.in_avail && (m_occ < DEPTH));
         checkOutput("wr_valid", bus.wr_valid, sq.size() != 0);
         if (bus.wr_valid && sq.size() != 0) begin
            b = sq[0];
            checkOutput("wr_data", bus.wr_data, b.data);
            checkOutput("wr_addr", bus.wr_addr, b.addr);
            checkOutput("wr_size", bus.wr_size, b.size);
            checkOutput("wr_beat", bus.wr_beat, b.beat);
            checkOutput("wr_first", bus.wr_first, b.first);
            checkOutput("wr_last", bus.wr_last, b.last);
            checkOutput("wr_expun", bus.wr_expun, b.expun);
            if (bus.wr_ready) begin
               void'(sq.pop_front());
               if (b.last) begin
                  m_occ--;
                  if (!b.expun) m_lines = m_lines + 16'd1;
               end
            end
         end
         if (bus.in_take) begin
            m_occ++;
            if (bus.in_expun) begin
               b.data = '0; b.addr = bus.in_addr; b.size = bus.in_size;
               b.beat = 2'd0; b.first = 1'b1; b.last = 1'b1; b.expun = 1'b1;
               sq.push_back(b);
            end else begin
               for (int k = 0; k < 4; k++) begin
                  b.data  = bus.in_data[k*132 +: 132];
                  b.addr  = bus.in_addr;
                  b.size  = bus.in_size;
                  b.beat  = 2'(k);
                  b.first = (k == 0);
                  b.last  = (k == 3);
                  b.expun = 1'b0;
                  sq.push_back(b);
               end
            end
         end
      end
   end

   task automatic drain(input string name);
      int budget = 200;
      while (sq.size() != 0 && budget > 0) begin
         applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);
         budget--;
      end
      applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);
      if (sq.size() != 0) begin
         tests++;
         fails++;
         $display("[TB] FAIL %s: drain timeout, %0d beats left, required 0", name, sq.size());
      end
   endtask

   initial begin
      logic [527:0] a5;
      for (int i = 0; i < 66; i++) a5[i*8 +: 8] = 8'hA5;
      rst          = 1'b1;
      bus.in_avail = 1'b0;
      bus.wr_ready = 1'b0;
      bus.in_expun = 1'b0;
      bus.in_addr  = '0;
      bus.in_data  = '0;
      bus.in_size  = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);

      // Single A5 line streamed with ready held high
      applyStimulus(1'b1, 1'b1, 1'b0, 47'h0A5_1234_5678, a5);
      repeat (6) applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);

      // Expunge entry: one zero-data beat, no line count
      applyStimulus(1'b1, 1'b1, 1'b1, 47'h7FF_0000_1234, randData());
      repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);

      // Fill while the cache stalls, then release for back-to-back beats
      repeat (8) applyStimulus(1'b1, 1'b0, 1'b0, 47'($urandom), randData());
      repeat (20) applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);

      // Ready toggling every cycle
      for (int c = 0; c < 40; c++)
         applyStimulus(1'($urandom_range(0, 1)), 1'(c % 2), 1'b0, 47'($urandom), randData());
      drain("drain_toggle");

      // Random traffic mixing expunges and stalls
      for (int c = 0; c < 300; c++)
         applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                       ($urandom_range(0, 7) == 0), {15'($urandom), 32'($urandom)}, randData());
      drain("drain_random");

      // Reset after beat 1 of a line, then a fresh line
      applyStimulus(1'b1, 1'b1, 1'b0, 47'h1_2345, randData());
      applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);
      applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);
      rst = 1'b1;
      applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);
      rst = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);
      applyStimulus(1'b1, 1'b1, 1'b0, 47'h2_3456, randData());
      drain("drain_after_reset");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/tile_xy_mort_sink.md
TILE_XY_MORT_SINK -- requirements
Module: tile_xy_mort_sink

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered line entries (power of two, 2..16).
REQ-002 SHALL have parameter BEATS, default 4, write beats per 528-bit line (fixed 4; beat width 132).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_avail  input  1  upstream tile FIFO holds at least one mortgage entry.
REQ-006 SHALL have port in_take  output  1  pop strobe to upstream (drives its outen); entry captured same edge.
REQ-007 SHALL have port in_data  input  528  line data (66x8).
REQ-008 SHALL have port in_addr  input  47  {tileY[4:0],tileX[4:0],addr[36:0]}.
REQ-009 SHALL have port in_size  input  12  {shared,exclusive,phymsk}.
REQ-010 SHALL have port in_expun  input  1  expunge entry; carries no data.
REQ-011 SHALL have port wr_valid  output  1  beat valid to local cache write port.
REQ-012 SHALL have port wr_ready  input  1  cache accepts beat.
REQ-013 SHALL have port wr_data  output  132  current beat data.
REQ-014 SHALL have port wr_addr  output  47  line address, constant across beats.
REQ-015 SHALL have port wr_size  output  12  pass-through of in_size.
REQ-016 SHALL have port wr_beat  output  2  beat index 0..3.
REQ-017 SHALL have port wr_first, wr_last, wr_expun  output  1 each  beat framing and expunge flag.
REQ-018 SHALL have port occ  output  5  entries currently buffered (0..DEPTH).
REQ-019 SHALL have port line_cnt  output  16  completed data lines, wraps 65535->0.

Function
REQ-020 SHALL drive in_take = in_avail & (occ < DEPTH), using registered occ (pop in same cycle does not free a slot).
REQ-021 SHALL write {in_data,in_addr,in_size,in_expun} into FIFO tail at every edge where in_take=1.
REQ-022 SHALL implement FSM IDLE/SEND; IDLE with occ>0 -> SEND, loading FIFO head into output register, beat=0.
REQ-023 SHALL, in SEND, hold wr_valid=1 and all wr_* stable until wr_valid&wr_ready.
REQ-024 SHALL output beat k data as line bits [132k+131:132k]; wr_first=(beat==0), wr_last=(beat==3).
REQ-025 SHALL send expunge entries as one beat: wr_first=wr_last=wr_expun=1, wr_data=0, wr_beat=0.
REQ-026 SHALL, on handshake of non-last beat, increment beat; on last-beat handshake pop FIFO head.
REQ-027 SHALL, on last-beat handshake with another entry buffered, load it directly (no bubble); else go IDLE, wr_valid=0.
REQ-028 SHALL present an entry accepted at edge N on wr_valid from cycle N+1 when FIFO empty and FSM IDLE.
REQ-029 SHALL update occ = occ + push - pop each edge; simultaneous push and pop leaves occ unchanged.
REQ-030 SHALL increment line_cnt on last-beat handshake of non-expunge entries only.
REQ-031 SHALL wrap FIFO read/write pointers modulo DEPTH.

Reset
REQ-032 SHALL, on rst=1, set occ=0, pointers=0, FSM=IDLE, wr_valid=0, beat=0, line_cnt=0, discarding any in-progress line; in_take=0 in the cycle after reset.

Verification
REQ-033 Single line 0xA5-pattern, wr_ready=1 -> wr_valid cycles 1..4, wr_beat 0,1,2,3, wr_last at beat 3, line_cnt=1.
REQ-034 in_avail held 1, wr_ready=0 -> exactly 4 pops, occ=4, in_take=0 thereafter; release ready -> 16 beats back-to-back, no bubble.
REQ-035 Expunge entry addr 0x7FF_0000_1234 -> one beat, wr_expun=1, wr_data=0, line_cnt unchanged.
REQ-036 wr_ready toggling 1/0 every cycle -> wr_data/wr_addr stable while stalled; beat order preserved.
REQ-037 rst asserted after beat 1 of a line -> next cycle wr_valid=0, occ=0, line_cnt=0; subsequent line starts at beat 0.
